// File: rtl/neighbor_table_ctrl_if.sv
// Bundle between the neighbor-table sequencer and its clients: packet intake, best-neighbor scan
// result, and the single read/write port of the table storage (read is combinational at tbl_addr).
interface neighbor_table_ctrl_if #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_W      = 5
);
  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [WORD_WIDTH-1:0] pkt_nodeID;
  logic [WORD_WIDTH-1:0] pkt_hops;
  logic [WORD_WIDTH-1:0] pkt_qvalue;
  logic [WORD_WIDTH-1:0] pkt_energy;
  logic [WORD_WIDTH-1:0] pkt_chhops;

  logic                  best_req;
  logic                  best_valid;
  logic                  best_none;
  logic [WORD_WIDTH-1:0] best_nodeID;
  logic [WORD_WIDTH-1:0] best_qvalue;
  logic [IDX_W-1:0]      best_idx;

  logic [IDX_W-1:0]      tbl_addr;
  logic [WORD_WIDTH-1:0] tbl_rd_nodeID;
  logic [WORD_WIDTH-1:0] tbl_rd_qvalue;
  logic                  tbl_wr_en;
  logic [WORD_WIDTH-1:0] tbl_wr_nodeID;
  logic [WORD_WIDTH-1:0] tbl_wr_hops;
  logic [WORD_WIDTH-1:0] tbl_wr_qvalue;
  logic [WORD_WIDTH-1:0] tbl_wr_energy;
  logic [WORD_WIDTH-1:0] tbl_wr_chhops;

  logic [5:0]            neighborCount;
  logic                  table_full;
  logic                  drop_pulse;

  // The controller responds to requests, so it takes the slave side.
  modport slave (
    input  pkt_valid, pkt_nodeID, pkt_hops, pkt_qvalue, pkt_energy, pkt_chhops,
    input  best_req, tbl_rd_nodeID, tbl_rd_qvalue,
    output pkt_ready, best_valid, best_none, best_nodeID, best_qvalue, best_idx,
    output tbl_addr, tbl_wr_en, tbl_wr_nodeID, tbl_wr_hops, tbl_wr_qvalue,
    output tbl_wr_energy, tbl_wr_chhops, neighborCount, table_full, drop_pulse
  );

  modport master (
    output pkt_valid, pkt_nodeID, pkt_hops, pkt_qvalue, pkt_energy, pkt_chhops,
    output best_req, tbl_rd_nodeID, tbl_rd_qvalue,
    input  pkt_ready, best_valid, best_none, best_nodeID, best_qvalue, best_idx,
    input  tbl_addr, tbl_wr_en, tbl_wr_nodeID, tbl_wr_hops, tbl_wr_qvalue,
    input  tbl_wr_energy, tbl_wr_chhops, neighborCount, table_full, drop_pulse
  );
endinterface

// File: rtl/neighbor_table_ctrl.sv
// Neighbor table sequencer: update-or-append packets (k+2 cycles for a hit at k, n+1 for an append), max-Q scans.
// Requests are taken only in IDLE with pkt_ready high; requests outside IDLE are ignored, and HB_reset aborts anything.
module neighbor_table_ctrl #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 32,
  parameter int IDX_W         = 5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 HB_reset,
  neighbor_table_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_WRITE, S_SCAN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      tgt;
  logic                  append;
  logic [5:0]            cnt;

  logic [WORD_WIDTH-1:0] cap_id, cap_hops, cap_q, cap_energy, cap_chhops;

  logic [WORD_WIDTH-1:0] run_id, run_q;
  logic [IDX_W-1:0]      run_idx;
  logic [WORD_WIDTH-1:0] best_id, best_q;
  logic [IDX_W-1:0]      best_idx_r;
  logic                  best_none_r;
  logic                  drop_r;

  logic                  hit, last, full, take;

  assign hit  = (bus.tbl_rd_nodeID == cap_id);
  assign last = (6'(idx) == (cnt - 6'd1));
  assign full = (cnt == 6'(MAX_NEIGHBORS));
  assign take = (bus.tbl_rd_qvalue > run_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (HB_reset) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.pkt_valid)
            state_nxt = (cnt == 6'd0) ? S_WRITE : S_SEARCH;
          else if (bus.best_req)
            state_nxt = (cnt <= 6'd1) ? S_DONE : S_SCAN;
        end
        S_SEARCH: begin
          if (hit)       state_nxt = S_WRITE;
          else if (last) state_nxt = full ? S_IDLE : S_WRITE;
        end
        S_WRITE: state_nxt = S_IDLE;
        S_SCAN:  if (last) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx         <= '0;
      tgt         <= '0;
      append      <= 1'b0;
      cnt         <= '0;
      cap_id      <= '0;
      cap_hops    <= '0;
      cap_q       <= '0;
      cap_energy  <= '0;
      cap_chhops  <= '0;
      run_id      <= '0;
      run_q       <= '0;
      run_idx     <= '0;
      best_id     <= '0;
      best_q      <= '0;
      best_idx_r  <= '0;
      best_none_r <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      if (HB_reset) begin
        // Entries are not wiped; a zero count is enough to make them dead.
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.pkt_valid) begin
              cap_id     <= bus.pkt_nodeID;
              cap_hops   <= bus.pkt_hops;
              cap_q      <= bus.pkt_qvalue;
              cap_energy <= bus.pkt_energy;
              cap_chhops <= bus.pkt_chhops;
              idx        <= '0;
              tgt        <= '0;
              append     <= (cnt == 6'd0);
            end else if (bus.best_req) begin
              if (cnt == 6'd0) begin
                best_none_r <= 1'b1;
              end else begin
                // tbl_addr is 0 in IDLE, so entry 0 is on the read port now.
                best_none_r <= 1'b0;
                idx         <= IDX_W'(1);
                if (cnt == 6'd1) begin
                  best_id    <= bus.tbl_rd_nodeID;
                  best_q     <= bus.tbl_rd_qvalue;
                  best_idx_r <= '0;
                end else begin
                  run_id  <= bus.tbl_rd_nodeID;
                  run_q   <= bus.tbl_rd_qvalue;
                  run_idx <= '0;
                end
              end
            end
          end
          S_SEARCH: begin
            if (hit) begin
              tgt    <= idx;
              append <= 1'b0;
            end else if (last) begin
              if (full) begin
                drop_r <= 1'b1;
              end else begin
                tgt    <= cnt[IDX_W-1:0];
                append <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_WRITE: begin
            if (append) cnt <= cnt + 6'd1;
          end
          S_SCAN: begin
            // The running max is kept apart so an aborted scan leaves best_* untouched.
            if (last) begin
              best_id    <= take ? bus.tbl_rd_nodeID : run_id;
              best_q     <= take ? bus.tbl_rd_qvalue : run_q;
              best_idx_r <= take ? idx : run_idx;
            end else begin
              if (take) begin
                run_id  <= bus.tbl_rd_nodeID;
                run_q   <= bus.tbl_rd_qvalue;
                run_idx <= idx;
              end
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.tbl_addr = '0;
    case (state)
      S_SEARCH, S_SCAN: bus.tbl_addr = idx;
      S_WRITE:          bus.tbl_addr = tgt;
      default:          bus.tbl_addr = '0;
    endcase
  end

  assign bus.pkt_ready     = (state == S_IDLE) && !HB_reset;
  assign bus.tbl_wr_en     = (state == S_WRITE) && !HB_reset;
  assign bus.tbl_wr_nodeID = cap_id;
  assign bus.tbl_wr_hops   = cap_hops;
  assign bus.tbl_wr_qvalue = cap_q;
  assign bus.tbl_wr_energy = cap_energy;
  assign bus.tbl_wr_chhops = cap_chhops;

  assign bus.best_valid    = (state == S_DONE);
  assign bus.best_none     = best_none_r;
  assign bus.best_nodeID   = best_id;
  assign bus.best_qvalue   = best_q;
  assign bus.best_idx      = best_idx_r;

  assign bus.neighborCount = cnt;
  assign bus.table_full    = full;
  assign bus.drop_pulse    = drop_r;

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// Bench for neighbor_table_ctrl: table storage model plus a queue-based reference of the neighbor list.
module tb_neighbor_table_ctrl;
  localparam int WW   = 16;
  localparam int MAXN = 32;
  localparam int IW   = 5;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic HB_reset = 1'b0;
  always #5 clk = ~clk;

  neighbor_table_ctrl_if #(.WORD_WIDTH(WW), .IDX_W(IW)) bus ();

  neighbor_table_ctrl #(.WORD_WIDTH(WW), .MAX_NEIGHBORS(MAXN), .IDX_W(IW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .HB_reset (HB_reset),
    .bus      (bus)
  );

  logic [WW-1:0] mem_id [MAXN];
  logic [WW-1:0] mem_q  [MAXN];
  assign bus.tbl_rd_nodeID = mem_id[bus.tbl_addr];
  assign bus.tbl_rd_qvalue = mem_q[bus.tbl_addr];
  always @(posedge clk) begin
    if (bus.tbl_wr_en) begin
      mem_id[bus.tbl_addr] <= bus.tbl_wr_nodeID;
      mem_q[bus.tbl_addr]  <= bus.tbl_wr_qvalue;
    end
  end

  // Reference: ordered list of live neighbors plus last published scan result.
  logic [WW-1:0] m_id[$];
  logic [WW-1:0] m_q[$];
  logic [WW-1:0] m_best_id = '0;
  logic [WW-1:0] m_best_q  = '0;
  logic [IW-1:0] m_best_idx = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_best(output logic [WW-1:0] id, output logic [WW-1:0] q, output logic [IW-1:0] ix);
    id = m_id[0]; q = m_q[0]; ix = '0;
    for (int i = 1; i < m_id.size(); i++)
      if (m_q[i] > q) begin id = m_id[i]; q = m_q[i]; ix = IW'(i); end
  endtask

  // hb_at > 0 asserts HB_reset for one cycle at that cycle after acceptance.
  task automatic send_pkt(input logic [WW-1:0] id, input logic [WW-1:0] q, input int hb_at);
    int n, k, wr_c, wr_n, dr_c, dr_n;
    logic [IW-1:0] wr_a;
    logic [WW-1:0] h, e, ch, g_id, g_h, g_q, g_e, g_ch;
    h = WW'($urandom); e = WW'($urandom); ch = WW'($urandom);
    n = m_id.size(); k = -1;
    foreach (m_id[i]) if (k < 0 && m_id[i] == id) k = i;
    wr_c = 0; wr_n = 0; dr_c = 0; dr_n = 0; wr_a = '0;
    g_id = '0; g_h = '0; g_q = '0; g_e = '0; g_ch = '0;
    chk("pkt_ready_before", bus.pkt_ready, 1);
    bus.pkt_valid = 1'b1; bus.pkt_nodeID = id; bus.pkt_qvalue = q;
    bus.pkt_hops = h; bus.pkt_energy = e; bus.pkt_chhops = ch;
    @(posedge clk); @(negedge clk);
    bus.pkt_valid = 1'b0;
    for (int c = 1; c <= n + 3; c++) begin
      HB_reset = (c == hb_at);
      #1;
      if (bus.tbl_wr_en) begin
        wr_n++;
        if (wr_n == 1) begin
          wr_c = c; wr_a = bus.tbl_addr; g_id = bus.tbl_wr_nodeID; g_q = bus.tbl_wr_qvalue;
          g_h = bus.tbl_wr_hops; g_e = bus.tbl_wr_energy; g_ch = bus.tbl_wr_chhops;
        end
      end
      if (bus.drop_pulse) begin dr_n++; dr_c = c; end
      if (c == hb_at) chk("hb_pkt_ready", bus.pkt_ready, 0);
      @(negedge clk);
    end
    HB_reset = 1'b0;
    if (hb_at > 0) begin
      chk("hb_no_write", wr_n, 0);
      chk("hb_no_drop", dr_n, 0);
      m_id.delete(); m_q.delete();
    end else if (k >= 0 || n < MAXN) begin
      chk("write_count", wr_n, 1);
      chk("write_cycle", wr_c, (k >= 0) ? k + 2 : n + 1);
      chk("write_addr", wr_a, (k >= 0) ? k : n);
      chk("write_id", g_id, id);
      chk("write_q", g_q, q);
      chk("write_hops", g_h, h);
      chk("write_energy", g_e, e);
      chk("write_chhops", g_ch, ch);
      chk("no_drop", dr_n, 0);
      if (k >= 0) m_q[k] = q;
      else begin m_id.push_back(id); m_q.push_back(q); end
    end else begin
      chk("drop_no_write", wr_n, 0);
      chk("drop_count", dr_n, 1);
      chk("drop_cycle", dr_c, n + 1);
    end
    #1;
    chk("count_after", bus.neighborCount, m_id.size());
    chk("full_after", bus.table_full, m_id.size() == MAXN);
    chk("pkt_ready_after", bus.pkt_ready, 1);
  endtask

  task automatic do_scan();
    int n, v_c, v_n;
    logic [WW-1:0] eid, eq, g_id, g_q;
    logic [IW-1:0] eix, g_ix;
    logic g_none;
    n = m_id.size(); v_c = 0; v_n = 0;
    g_id = '0; g_q = '0; g_ix = '0; g_none = 1'b0;
    if (n == 0) begin eid = m_best_id; eq = m_best_q; eix = m_best_idx; end
    else model_best(eid, eq, eix);
    bus.best_req = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.best_req = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      #1;
      if (bus.best_valid) begin
        v_n++; v_c = c; g_id = bus.best_nodeID; g_q = bus.best_qvalue;
        g_ix = bus.best_idx; g_none = bus.best_none;
      end
      @(negedge clk);
    end
    chk("scan_valid_pulses", v_n, 1);
    chk("scan_valid_cycle", v_c, (n == 0) ? 1 : n);
    chk("scan_none", g_none, n == 0);
    chk("scan_id", g_id, eid);
    chk("scan_q", g_q, eq);
    chk("scan_idx", g_ix, eix);
    m_best_id = eid; m_best_q = eq; m_best_idx = eix;
  endtask

  task automatic hb_pulse();
    HB_reset = 1'b1;
    #1;
    chk("hb_idle_ready", bus.pkt_ready, 0);
    chk("hb_idle_wr", bus.tbl_wr_en, 0);
    @(negedge clk);
    HB_reset = 1'b0;
    #1;
    chk("hb_idle_count", bus.neighborCount, 0);
    m_id.delete(); m_q.delete();
  endtask

  int pn, p_wr, p_v;
  logic [WW-1:0] p_q, p_gq, p_eid, p_eq;
  logic [IW-1:0] p_gix, p_eix;

  initial begin
    bus.pkt_valid = 0; bus.best_req = 0;
    bus.pkt_nodeID = '0; bus.pkt_hops = '0; bus.pkt_qvalue = '0;
    bus.pkt_energy = '0; bus.pkt_chhops = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_pkt_ready", bus.pkt_ready, 1);
    chk("rst_count", bus.neighborCount, 0);
    chk("rst_full", bus.table_full, 0);
    chk("rst_best_valid", bus.best_valid, 0);
    chk("rst_best_none", bus.best_none, 0);
    chk("rst_best_id", bus.best_nodeID, 0);
    chk("rst_best_q", bus.best_qvalue, 0);
    chk("rst_best_idx", bus.best_idx, 0);
    chk("rst_wr_en", bus.tbl_wr_en, 0);
    chk("rst_drop", bus.drop_pulse, 0);
    chk("rst_addr", bus.tbl_addr, 0);
    chk("rst_wr_id", bus.tbl_wr_nodeID, 0);
    @(negedge clk);

    // Directed: append, update in place, tie-breaking scan.
    send_pkt(16'h0003, 16'h0100, 0);
    send_pkt(16'h0007, 16'h0050, 0);
    send_pkt(16'h0009, 16'h0500, 0);
    send_pkt(16'h0007, 16'h0500, 0);
    send_pkt(16'h000B, 16'h0200, 0);
    do_scan();

    // Empty table scan keeps previous best_* and flags none.
    hb_pulse();
    do_scan();

    // Heartbeat mid-SEARCH, then during WRITE; next packet lands at index 0.
    for (int i = 0; i < 5; i++) send_pkt(WW'(16'h0020 + i), WW'($urandom), 0);
    send_pkt(16'h0040, 16'h1234, 2);
    send_pkt(16'h0020, 16'h0777, 0);
    send_pkt(16'h0021, 16'h0111, 0);
    send_pkt(16'h0041, 16'h0222, 3);
    send_pkt(16'h0022, 16'h0333, 0);

    // Randomized mix of updates, appends and scans.
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) do_scan();
      else send_pkt(WW'($urandom_range(0, 11)), WW'($urandom), 0);
    end

    // Packet and scan requested together: packet first, held scan afterwards.
    pn = m_id.size();
    p_q = WW'($urandom);
    bus.pkt_valid = 1'b1; bus.best_req = 1'b1;
    bus.pkt_nodeID = 16'h0077; bus.pkt_qvalue = p_q;
    @(posedge clk); @(negedge clk);
    bus.pkt_valid = 1'b0;
    p_wr = 0; p_v = 0; p_gq = '0; p_gix = '0;
    for (int c = 1; c <= 2 * pn + 8; c++) begin
      #1;
      if (bus.tbl_wr_en && p_wr == 0) p_wr = c;
      if (bus.best_valid && p_v == 0) begin
        p_v = c; bus.best_req = 1'b0; p_gq = bus.best_qvalue; p_gix = bus.best_idx;
      end
      @(negedge clk);
    end
    bus.best_req = 1'b0;
    m_id.push_back(16'h0077); m_q.push_back(p_q);
    model_best(p_eid, p_eq, p_eix);
    m_best_id = p_eid; m_best_q = p_eq; m_best_idx = p_eix;
    chk("prio_write_cycle", p_wr, pn + 1);
    chk("prio_scan_cycle", p_v, 2 * pn + 3);
    chk("prio_scan_q", p_gq, p_eq);
    chk("prio_scan_idx", p_gix, p_eix);

    // Fill to capacity, then a new ID is dropped.
    hb_pulse();
    for (int i = 0; i < MAXN; i++) send_pkt(WW'(16'h0100 + i), WW'($urandom), 0);
    send_pkt(16'h00FF, 16'h0FFF, 0);
    send_pkt(16'h011F, 16'h0ABC, 0);
    do_scan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
